iter_divider: RTL and testbench

- Multi-cycle integer divide unit; the inverse companion of the single-cycle MUL path in the execute stage.
- Computes quotient and remainder using restoring shift-subtract, one bit per clock.
- Sits beside the ALU and takes the same data0/data1 operands (dividend/divisor).
- Uses a start/busy/valid handshake so the pipeline control can stall while a divide is in flight.

---
 rtl/iter_divider.sv | 151 +++++++++++++++
 tb/tb_iter_divider.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/iter_divider.sv
// Multi-cycle restoring shift-subtract divider (one quotient bit per clock), RISC-V M semantics.
// Optional macro ITER_DIVIDER_EARLY_EXIT_EN skips leading-zero dividend bits to shorten latency.
module iter_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] data0_i,
    input  logic [WIDTH-1:0] data1_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_INIT = CW'(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;    // partial remainder
    logic [WIDTH-1:0] quo_q, quo_d;    // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;

    logic [WIDTH-1:0] abs0, abs1;
    logic             div_zero, ovf;
    logic [WIDTH:0]   rem_sh, trial;
    logic             q_bit;
    logic [WIDTH-1:0] rem_nx, quo_nx;

`ifdef ITER_DIVIDER_EARLY_EXIT_EN
    function automatic logic [CW-1:0] lzc(input logic [WIDTH-1:0] v);
        lzc = CNT_INIT;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) lzc = CW'(WIDTH - 1 - i);
        end
    endfunction

    logic [CW-1:0] lz;
    assign lz = lzc(abs0);
`endif

    assign abs0     = (signed_i && data0_i[WIDTH-1]) ? -data0_i : data0_i;
    assign abs1     = (signed_i && data1_i[WIDTH-1]) ? -data1_i : data1_i;
    assign div_zero = (data1_i == '0);
    assign ovf      = signed_i && (data0_i == MIN_NEG) && (data1_i == '1);

    // One extra bit on the trial subtract: its MSB is the borrow that decides the quotient bit.
    assign rem_sh = {rem_q, quo_q[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, div_q};
    assign q_bit  = ~trial[WIDTH];
    assign rem_nx = q_bit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign quo_nx = {quo_q[WIDTH-2:0], q_bit};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        div_d   = div_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start_i) begin
                    if (div_zero) begin
                        quot_d  = '1;
                        remo_d  = data0_i;
                        state_d = DONE;
                    end else if (ovf) begin
                        quot_d  = MIN_NEG;
                        remo_d  = '0;
                        state_d = DONE;
                    end
`ifdef ITER_DIVIDER_EARLY_EXIT_EN
                    else if (abs0 == '0) begin
                        quot_d  = '0;
                        remo_d  = '0;
                        state_d = DONE;
                    end
`endif
                    else begin
                        rem_d   = '0;
`ifdef ITER_DIVIDER_EARLY_EXIT_EN
                        quo_d   = abs0 << lz;
                        cnt_d   = CNT_INIT - lz;
`else
                        quo_d   = abs0;
                        cnt_d   = CNT_INIT;
`endif
                        div_d   = abs1;
                        qneg_d  = signed_i & (data0_i[WIDTH-1] ^ data1_i[WIDTH-1]);
                        rneg_d  = signed_i & data0_i[WIDTH-1];
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == 1) begin
                    quot_d  = qneg_q ? -quo_nx : quo_nx;
                    remo_d  = rneg_q ? -rem_nx : rem_nx;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            quot_q  <= '0;
            remo_q  <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end

    assign busy_o      = (state_q == CALC);
    assign valid_o     = (state_q == DONE);
    assign quotient_o  = quot_q;
    assign remainder_o = remo_q;
endmodule

// File: tb/tb_iter_divider.sv
// Directed + random bench for iter_divider; expected results come from a behavioural
// RISC-V M reference model and are queued at issue, popped when valid_o appears.
module tb_iter_divider;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, start, sgn;
    logic [W-1:0] d0, d1, q, r;
    logic         busy, valid;

    always #5 clk = ~clk;

    iter_divider #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .signed_i(sgn),
        .data0_i(d0), .data1_i(d1), .busy_o(busy), .valid_o(valid),
        .quotient_o(q), .remainder_o(r)
    );

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int checks = 0, errors = 0;
    int cyc = 0, busy_cnt = 0, acc_cyc = 0, busy0 = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t e;
        e.lat = W + 1;
        if (b == '0) begin
            e.q = '1; e.r = a; e.lat = 1;
        end else if (s && a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
            e.q = a; e.r = '0; e.lat = 1;
        end else if (s) begin
            e.q = $signed(a) / $signed(b);
            e.r = $signed(a) % $signed(b);
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        sb.push_back(model(a, b, s));
        start = 1'b1; d0 = a; d1 = b; sgn = s;
        @(posedge clk); #1;
        start   = 1'b0;
        d0      = $urandom; d1 = $urandom; sgn = ~s;
        acc_cyc = cyc;
        busy0   = busy_cnt;
    endtask

    task automatic wait_result(input string tag);
        exp_t e;
        int n = 0;
        while (!valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " valid"}, 64'(valid), 64'(1));
        if (sb.size() == 0) begin
            check({tag, " queue"}, 64'(0), 64'(1));
        end else begin
            e = sb.pop_front();
            check({tag, " latency"}, 64'(cyc - acc_cyc + 1), 64'(e.lat));
            check({tag, " busy"}, 64'(busy_cnt - busy0), 64'(e.lat - 1));
            check({tag, " quot"}, 64'(q), 64'(e.q));
            check({tag, " rem"}, 64'(r), 64'(e.r));
        end
    endtask

    logic [W-1:0] ta[8] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'd5, 32'hFFFF_FF9C,
                            32'd100, 32'h8000_0000, 32'd0, 32'd0};
    logic [W-1:0] tb_[8] = '{32'd1, 32'd1, 32'd10, 32'd7,
                             32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'd5, 32'd0};
    logic         ts[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        int seen;
        rst = 1'b1; start = 1'b0; sgn = 1'b0; d0 = '0; d1 = '0;
        #1;
        check("reset busy", 64'(busy), 64'(0));
        check("reset valid", 64'(valid), 64'(0));
        check("reset quot", 64'(q), 64'(0));
        check("reset rem", 64'(r), 64'(0));
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        start_op(32'd100, 32'd7, 1'b0);
        wait_result("u100_7");
        check("u100_7 q14", 64'(q), 64'(14));
        check("u100_7 r2", 64'(r), 64'(2));

        start_op(32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_result("s-7_2");
        check("s-7_2 q", 64'(q), 64'hFFFF_FFFD);
        check("s-7_2 r", 64'(r), 64'hFFFF_FFFF);

        start_op(32'h1234_5678, 32'd0, 1'b0);
        wait_result("div0");
        start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_result("ovf");

        // start during CALC must be ignored; start during DONE is accepted
        start_op(32'd100, 32'd7, 1'b0);
        repeat (5) begin @(posedge clk); #1; end
        start = 1'b1; d0 = 32'd55; d1 = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        check("ignore busy", 64'(busy), 64'(1));
        wait_result("ignore");
        check("ignore q14", 64'(q), 64'(14));
        start_op(32'd9, 32'd3, 1'b0);
        wait_result("b2b");
        check("b2b q3", 64'(q), 64'(3));
        @(posedge clk); #1;
        check("pulse one cycle", 64'(valid), 64'(0));
        check("hold quot", 64'(q), 64'(3));

        for (int i = 0; i < 8; i++) begin
            start_op(ta[i], tb_[i], ts[i]);
            wait_result($sformatf("edge%0d", i));
        end
        for (int i = 0; i < 6; i++) begin
            start_op($urandom, $urandom >> $urandom_range(0, 31), i[0]);
            wait_result($sformatf("rand%0d", i));
        end

        // async reset in the middle of a divide
        start_op(32'd100, 32'd7, 1'b0);
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        check("midrst busy", 64'(busy), 64'(0));
        check("midrst valid", 64'(valid), 64'(0));
        check("midrst quot", 64'(q), 64'(0));
        check("midrst rem", 64'(r), 64'(0));
        void'(sb.pop_back());
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (valid) seen++;
        end
        check("midrst no valid", 64'(seen), 64'(0));
        start_op(32'd1000, 32'd33, 1'b0);
        wait_result("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
